// File: rtl/ysyx_22050612_ifq.sv
// In-order instruction fetch into a DEPTH-entry {pc,inst} FIFO. Entries reach inst_valid one cycle after a response.
// Issue is credit-limited by FIFO occupancy plus in-flight requests, so decode backpressure stalls mem_req; redirect flushes.

module ysyx_22050612_ifq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ysyx_22050612_ifq #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [63:0]   target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW-1:0] out_after_resp;
  logic [CW:0]   credit_used;
  logic          grant;
  logic          push;
  logic          pop;
  entry_t        push_entry;
  entry_t        head;

  assign target_pc   = {redirect_pc[63:2], 2'b00};
  assign credit_used = {1'b0, count} + {1'b0, outstanding};

  // Gating on rst keeps both handshakes quiet while state is being reset.
  assign mem_req  = rst && !redirect_valid && (credit_used < LIMIT);
  assign mem_addr = fetch_pc;
  assign grant    = mem_req && mem_gnt;

  assign out_after_resp = outstanding - (mem_rvalid ? CW'(1) : '0);
  assign push           = rst && mem_rvalid && !redirect_valid && (discard == '0);

  assign inst_valid = rst && (count != '0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  assign push_entry.pc   = resp_pc;
  assign push_entry.inst = mem_rdata;

  ysyx_22050612_ifq_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_after_resp + (grant ? CW'(1) : '0);
      if (redirect_valid) begin
        // Every request still in flight after this cycle is stale.
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        discard  <= out_after_resp;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (mem_rvalid) begin
          if (discard != '0) begin
            discard <= discard - CW'(1);
          end else begin
            resp_pc <= resp_pc + 64'd4;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_ifq.sv
module tb_ysyx_22050612_ifq;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;

  ysyx_22050612_ifq #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          due;
  } mreq_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  mreq_t       mq[$];
  ent_t        sb[$];
  logic [63:0] exp_fetch;
  int          cyc;
  int          lat;
  logic        mode13;
  int          checks;
  int          errors;
  int          grants;
  int          pops;
  logic [63:0] first_pc;
  logic        s_req;
  logic [63:0] s_addr;
  logic        s_valid;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return mode13 ? 32'h0000_0013 : (a[31:0] ^ 32'hDEAD_0003);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory side, sample/check outputs, then advance the model.
  task automatic step();
    logic        req_l, gnt_l, rv_l, rdr_l, rst_l;
    logic [63:0] addr_l, rpc_l;
    ent_t        e;
    mreq_t       m;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mq[0].data;
    end
    mem_gnt = 1'b1;
    #1;
    req_l = mem_req; addr_l = mem_addr; gnt_l = mem_gnt; rv_l = mem_rvalid;
    rdr_l = redirect_valid; rpc_l = redirect_pc; rst_l = rst;
    s_req = mem_req; s_addr = mem_addr; s_valid = inst_valid;
    if (!rst || redirect_valid) begin
      check("req_low", mem_req, 0);
      check("valid_low", inst_valid, 0);
    end
    if (mem_req) check("mem_addr", mem_addr, exp_fetch);
    if (inst_valid && inst_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", {32'h0, inst}, {32'h0, e.inst});
        if (pops == 0) first_pc = inst_pc;
        pops++;
      end
    end
    if (mem_req && mem_gnt) grants++;
    @(posedge clk);
    #1;
    if (!rst_l) begin
      mq.delete();
      sb.delete();
      exp_fetch = RESET_PC;
    end else begin
      if (rv_l) m = mq.pop_front();
      if (rdr_l) begin
        sb.delete();
        exp_fetch = {rpc_l[63:2], 2'b00};
      end else if (req_l && gnt_l) begin
        mq.push_back('{addr_l, data_of(addr_l), cyc + lat});
        sb.push_back('{exp_fetch, data_of(exp_fetch)});
        exp_fetch = exp_fetch + 64'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    checks = 0; errors = 0; grants = 0; pops = 0; cyc = 0; lat = 1; mode13 = 1'b1;
    first_pc = '0; exp_fetch = RESET_PC;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset, then streaming with 1-cycle memory: 2-cycle fill, then 1/cycle.
    repeat (2) step();
    rst = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t1_valid", s_valid, (i >= 2) ? 1 : 0);
    end
    check("t1_pops", pops, 8);
    check("t1_first_pc", first_pc, RESET_PC);

    // Decode stalled: exactly DEPTH grants, then drain in order and resume.
    mode13 = 1'b0;
    rst = 1'b0; step(); rst = 1'b1;
    inst_ready = 1'b0; grants = 0; pops = 0;
    repeat (8) step();
    check("t2_grants", grants, 4);
    check("t2_req_stalled", s_req, 0);
    check("t2_full_valid", s_valid, 1);
    inst_ready = 1'b1;
    repeat (4) step();
    check("t2_pops", pops, 4);
    check("t2_first_pc", first_pc, RESET_PC);
    check("t2_resume", grants > 4, 1);

    // Redirect with 3 requests in flight on a 3-cycle memory.
    rst = 1'b0; step(); rst = 1'b1;
    lat = 3; pops = 0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1003;
    step();
    redirect_valid = 1'b0;
    step();
    check("t3_req", s_req, 1);
    check("t3_addr", s_addr, 64'h8000_1000);
    repeat (12) step();
    check("t3_first_pc", first_pc, 64'h8000_1000);
    check("t3_popped", pops > 0, 1);

    // Redirect colliding with a response and a pop.
    lat = 2;
    repeat (10) step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; pops = 0;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    check("t4_first_pc", first_pc, 64'h8000_2000);

    // Reset with 2 buffered and 2 outstanding.
    rst = 1'b0; step(); rst = 1'b1;
    inst_ready = 1'b0;
    repeat (4) step();
    check("t5_buffered", s_valid, 1);
    rst = 1'b0; step(); rst = 1'b1;
    step();
    check("t5_valid", s_valid, 0);
    check("t5_addr", s_addr, RESET_PC);
    inst_ready = 1'b1; pops = 0;
    repeat (8) step();
    check("t5_first_pc", first_pc, RESET_PC);

    // Address wrap at the top of the 64-bit space.
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8; pops = 0;
    step();
    redirect_valid = 1'b0;
    step();
    check("t6_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (10) step();
    check("t6_first_pc", first_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    check("t6_pops", pops >= 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050612_ifq.md
# ysyx_22050612_ifq

Instruction fetch queue for the ysyx_22050612 core: issues in-order 32-bit instruction reads to instruction memory over a request/grant/response handshake and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It sits directly upstream of the decode stage, presenting one instruction per valid/ready handshake. The execute stage redirects it with the next PC on any control-flow change.

## Interface
- DEPTH, 4, FIFO entries and max in-flight requests; power of two, ≥2
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous and active-low
- redirect_valid  in  1  flush and restart fetch this cycle
- redirect_pc  in  64  restart address; bits [1:0] ignored, treated as 0
- mem_req  out  1  read request valid
- mem_addr  out  64  read address, 4-byte aligned
- mem_gnt  in  1  request accepted this cycle (meaningful only with mem_req)
- mem_rvalid  in  1  read data returning; responses strictly in request order, earliest 1 cycle after grant
- mem_rdata  in  32  instruction word
- inst_valid  out  1  head entry available
- inst  out  32  head instruction
- inst_pc  out  64  PC of head instruction
- inst_ready  in  1  decode consumes head

## Operation
- State: fetch_pc (next issue address), resp_pc (PC of next accepted response), FIFO (count 0..DEPTH, {pc,inst} entries), outstanding (0..DEPTH, $clog2(DEPTH)+1 bits), discard (0..DEPTH, same width).
- Issue: mem_req = !redirect_valid && (count + outstanding < DEPTH); mem_addr = fetch_pc. On mem_req && mem_gnt: fetch_pc += 4 (mod 2^64), outstanding += 1.
- Response: on mem_rvalid, outstanding -= 1. If discard != 0: discard -= 1, data dropped. Else push {resp_pc, mem_rdata}; resp_pc += 4.
- Credit rule guarantees every accepted response has a free slot; push to a full FIFO never occurs.
- Pop: inst_valid = (count != 0) && !redirect_valid; head popped on inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority): FIFO emptied, fetch_pc <= resp_pc <= {redirect_pc[63:2],2'b00}, discard <= outstanding after this cycle's response decrement (all in-flight requests become stale). A response arriving in the redirect cycle is dropped. No grant can occur in a redirect cycle (mem_req low).
- Once mem_req is raised, mem_addr holds stable until grant; only redirect or reset may withdraw it.

## Timing
- Reset (rst == 0 at edge): fetch_pc = resp_pc = RESET_PC, count = outstanding = discard = 0; during and immediately after reset mem_req = 0 only while rst low, inst_valid = 0. mem_req may assert the first cycle rst is high.
- Reset mid-operation discards all in-flight state; instruction memory shares rst and drops its pending responses.
- Pushed entry visible on inst_valid the cycle after mem_rvalid (registered FIFO, no bypass).
- Latency grant → inst_valid: response latency + 1 cycle.
- Sustained throughput 1 instruction/cycle when memory grants every cycle with 1-cycle response and inst_ready held high.
- Back-to-back redirects: each reloads addresses; discard accumulates to current outstanding, never exceeds DEPTH.
- fetch_pc wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0 without error.

## Test plan
- Reset release, mem_gnt=1, 1-cycle response returning 32'h00000013 for each address, inst_ready=1 -> mem_addr 8000_0000, 8000_0004, ...; inst_pc sequence 8000_0000, 8000_0004 at 1/cycle after 2-cycle fill.
- inst_ready=0 throughout, DEPTH=4 -> exactly 4 grants, mem_req drops, count=4; raising inst_ready drains 4 entries in order then fetch resumes.
- 3 requests outstanding (3-cycle response latency), redirect_valid with redirect_pc=64'h8000_1003 -> next mem_addr 8000_1000, the 3 stale responses dropped, first inst_pc 8000_1000.
- Redirect in the same cycle as mem_rvalid and inst_valid&&inst_ready -> that response dropped, inst_valid low that cycle, discard = remaining outstanding.
- rst low for one cycle with 2 entries buffered and 2 outstanding -> next cycle inst_valid=0, mem_addr=RESET_PC, no stale data ever presented.
- Redirect to 64'hFFFF_FFFF_FFFF_FFF8 -> mem_addr FFF8, FFFC, 0000_0000_0000_0000, inst_pc follows identically.
